// File: rtl/mvm_pkg.sv
// rtl/mvm_pkg.sv - shared types and default sizes for the MVM stream arbiter
package mvm_pkg;

    localparam int N_DEF = 8;
    localparam int M_DEF = 8;
    localparam int W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        RECV = 2'd2
    } state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way round-robin picker
// Ports:
//   req[1:0]  request lines from requester 0 and 1
//   last      index of the requester served most recently
//   winner    index of the chosen requester (meaningful when req != 0)
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner
);

    always_comb begin
        winner = 1'b0;
        if (req == 2'b11) begin
            winner = ~last;
        end else if (req[1]) begin
            winner = 1'b1;
        end
    end

endmodule

// File: rtl/mvm_stream_arbiter.sv
// rtl/mvm_stream_arbiter.sv - shares one MVM layer between two requester streams
// Ports:
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   s0_*, s1_*                  requester input-vector streams (valid/ready/data)
//   m0_*, m1_*                  requester result streams (valid/ready/data)
//   l_s_valid/l_s_ready/l_data_in   towards the layer input port
//   l_m_valid/l_m_ready/l_data_out  from the layer output port
//   grant                       current owner index, meaningful while busy
//   busy                        high while a transaction is in SEND or RECV
//   txn_cnt0, txn_cnt1          per-requester completed transactions (MVM_ARB_PERF_EN only)
module mvm_stream_arbiter
    import mvm_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int M = M_DEF,
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         s0_valid,
    output logic         s0_ready,
    input  logic [W-1:0] s0_data,
    input  logic         s1_valid,
    output logic         s1_ready,
    input  logic [W-1:0] s1_data,
    output logic         m0_valid,
    input  logic         m0_ready,
    output logic [W-1:0] m0_data,
    output logic         m1_valid,
    input  logic         m1_ready,
    output logic [W-1:0] m1_data,
    output logic         l_s_valid,
    input  logic         l_s_ready,
    output logic [W-1:0] l_data_in,
    input  logic         l_m_valid,
    output logic         l_m_ready,
    input  logic [W-1:0] l_data_out,
    output logic         grant,
    output logic         busy
`ifdef MVM_ARB_PERF_EN
    ,
    output logic [15:0]  txn_cnt0,
    output logic [15:0]  txn_cnt1
`endif
);

    localparam int CW = $clog2(max2(N, M) + 1);
    localparam logic [CW-1:0] N_LAST = CW'(N - 1);
    localparam logic [CW-1:0] M_LAST = CW'(M - 1);

    state_t        r_state;
    state_t        w_next;
    logic          r_grant;
    logic          r_last;
    logic [CW-1:0] r_cnt;
    logic          w_winner;
    logic          w_sg_valid;
    logic          w_mg_ready;
    logic          w_send_beat;
    logic          w_recv_beat;
    logic          w_send_done;
    logic          w_recv_done;

    rr_arb2 u_rr_arb2 (
        .req    ({s1_valid, s0_valid}),
        .last   (r_last),
        .winner (w_winner)
    );

    assign w_sg_valid  = r_grant ? s1_valid : s0_valid;
    assign w_mg_ready  = r_grant ? m1_ready : m0_ready;
    assign w_send_beat = (r_state == SEND) && w_sg_valid && l_s_ready;
    assign w_recv_beat = (r_state == RECV) && l_m_valid && w_mg_ready;
    assign w_send_done = w_send_beat && (r_cnt == N_LAST);
    assign w_recv_done = w_recv_beat && (r_cnt == M_LAST);

    assign busy  = (r_state != IDLE) && !reset;
    assign grant = r_grant && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // One counter serves both phases; it is cleared on each phase exit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant <= 1'b0;
            r_last  <= 1'b1;
            r_cnt   <= '0;
        end else begin
            if ((r_state == IDLE) && (s0_valid || s1_valid)) begin
                r_grant <= w_winner;
            end
            if (w_send_beat || w_recv_beat) begin
                r_cnt <= (w_send_done || w_recv_done) ? '0 : r_cnt + 1'b1;
            end
            if (w_recv_done) begin
                r_last <= r_grant;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        s0_ready  = 1'b0;
        s1_ready  = 1'b0;
        m0_valid  = 1'b0;
        m1_valid  = 1'b0;
        m0_data   = '0;
        m1_data   = '0;
        l_s_valid = 1'b0;
        l_data_in = '0;
        l_m_ready = 1'b0;
        case (r_state)
            IDLE: begin
                if (s0_valid || s1_valid) begin
                    w_next = SEND;
                end
            end
            SEND: begin
                l_s_valid = w_sg_valid;
                l_data_in = r_grant ? s1_data : s0_data;
                s0_ready  = !r_grant && l_s_ready;
                s1_ready  = r_grant && l_s_ready;
                if (w_send_done) begin
                    w_next = RECV;
                end
            end
            RECV: begin
                m0_valid  = !r_grant && l_m_valid;
                m1_valid  = r_grant && l_m_valid;
                m0_data   = r_grant ? '0 : l_data_out;
                m1_data   = r_grant ? l_data_out : '0;
                l_m_ready = w_mg_ready;
                if (w_recv_done) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
        // Outputs go quiet in the very cycle reset is sampled, not one later.
        if (reset) begin
            s0_ready  = 1'b0;
            s1_ready  = 1'b0;
            m0_valid  = 1'b0;
            m1_valid  = 1'b0;
            m0_data   = '0;
            m1_data   = '0;
            l_s_valid = 1'b0;
            l_data_in = '0;
            l_m_ready = 1'b0;
        end
    end

`ifdef MVM_ARB_PERF_EN
    logic [15:0] r_txn_cnt0;
    logic [15:0] r_txn_cnt1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_txn_cnt0 <= '0;
            r_txn_cnt1 <= '0;
        end else if (w_recv_done) begin
            if (!r_grant && (r_txn_cnt0 != 16'hFFFF)) begin
                r_txn_cnt0 <= r_txn_cnt0 + 16'd1;
            end
            if (r_grant && (r_txn_cnt1 != 16'hFFFF)) begin
                r_txn_cnt1 <= r_txn_cnt1 + 16'd1;
            end
        end
    end

    assign txn_cnt0 = r_txn_cnt0;
    assign txn_cnt1 = r_txn_cnt1;
`endif

endmodule

// File: tb/tb_mvm_stream_arbiter.sv
// tb/tb_mvm_stream_arbiter.sv - scoreboard bench for mvm_stream_arbiter
module tb_mvm_stream_arbiter;

    localparam int N = 8;
    localparam int M = 8;
    localparam int W = 16;

    typedef logic [W-1:0] word_t;
    typedef word_t vec_t [N];

    logic  clk = 1'b0;
    logic  reset = 1'b1;
    logic  s0_valid, s0_ready, s1_valid, s1_ready;
    word_t s0_data, s1_data;
    logic  m0_valid, m0_ready, m1_valid, m1_ready;
    word_t m0_data, m1_data;
    logic  l_s_valid, l_s_ready, l_m_valid, l_m_ready;
    word_t l_data_in, l_data_out;
    logic  grant, busy;
`ifdef MVM_ARB_PERF_EN
    logic [15:0] txn_cnt0, txn_cnt1;
`endif

    mvm_stream_arbiter #(.N(N), .M(M), .W(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .s0_valid   (s0_valid),
        .s0_ready   (s0_ready),
        .s0_data    (s0_data),
        .s1_valid   (s1_valid),
        .s1_ready   (s1_ready),
        .s1_data    (s1_data),
        .m0_valid   (m0_valid),
        .m0_ready   (m0_ready),
        .m0_data    (m0_data),
        .m1_valid   (m1_valid),
        .m1_ready   (m1_ready),
        .m1_data    (m1_data),
        .l_s_valid  (l_s_valid),
        .l_s_ready  (l_s_ready),
        .l_data_in  (l_data_in),
        .l_m_valid  (l_m_valid),
        .l_m_ready  (l_m_ready),
        .l_data_out (l_data_out),
        .grant      (grant),
        .busy       (busy)
`ifdef MVM_ARB_PERF_EN
        ,
        .txn_cnt0   (txn_cnt0),
        .txn_cnt1   (txn_cnt1)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference layer function: y[k] = sum_j x[j] * (k + 2j + 1), modulo 2^W.
    function automatic word_t mvm_result(input vec_t v, input int k);
        word_t acc;
        acc = '0;
        for (int j = 0; j < N; j++) begin
            acc = acc + v[j] * word_t'(k + 2 * j + 1);
        end
        return acc;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        for (int j = 0; j < N; j++) v[j] = word_t'($urandom);
        return v;
    endfunction

    // Scoreboard queues, filled by the stimulus side.
    word_t exp_in0[$], exp_in1[$], exp_m0[$], exp_m1[$];

    // Stimulus knobs.
    int lsr_mode = 0;
    bit lmv_rand = 1'b0;
    bit mr_rand  = 1'b0;
    bit hold_m0  = 1'b0;
    bit abort_req = 1'b0;

    // Monitor / reference arbitration state.
    bit busy_q = 1'b0;
    bit grant_q = 1'b0;
    bit last_model = 1'b1;
    bit prev_s0v = 1'b0;
    bit prev_s1v = 1'b0;
    bit exp_g;
    int in_cnt = 0;
    int out_cnt = 0;
    int l_in_total = 0;
    int m0_beats_total = 0;
    int perf0_model = 0;
    int perf1_model = 0;
    int grant_log[$];

    // Shared MVM layer model: collect N words, then offer M results.
    word_t lay_in[$], lay_out[$];
    bit lay_hs_in, lay_hs_out, lsr_tog;

    initial begin
        l_s_ready = 1'b0;
        l_m_valid = 1'b0;
        l_data_out = '0;
        lsr_tog = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                lay_in.delete();
                lay_out.delete();
                lay_hs_in = 1'b0;
                lay_hs_out = 1'b0;
            end else begin
                lay_hs_in  = l_s_valid && l_s_ready;
                lay_hs_out = l_m_valid && l_m_ready;
                if (lay_hs_in) lay_in.push_back(l_data_in);
            end
            @(posedge clk);
            #1;
            if (lay_hs_out && lay_out.size() > 0) void'(lay_out.pop_front());
            if (lay_in.size() == N) begin
                vec_t v;
                for (int j = 0; j < N; j++) v[j] = lay_in[j];
                for (int k = 0; k < M; k++) lay_out.push_back(mvm_result(v, k));
                lay_in.delete();
            end
            lsr_tog = ~lsr_tog;
            case (lsr_mode)
                0: l_s_ready = 1'b1;
                1: l_s_ready = lsr_tog;
                default: l_s_ready = 1'($urandom_range(0, 1));
            endcase
            l_m_valid  = (lay_out.size() > 0) && (lmv_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
            l_data_out = (lay_out.size() > 0) ? lay_out[0] : '0;
        end
    end

    initial begin
        m0_ready = 1'b0;
        m1_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            m0_ready = hold_m0 ? 1'b0 : (mr_rand ? 1'($urandom_range(0, 1)) : 1'b1);
            m1_ready = mr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: samples on the falling edge, away from DUT updates.
    always @(negedge clk) begin
        if (reset) begin
            chk("reset_outputs", {busy, grant, s0_ready, s1_ready, m0_valid, m1_valid,
                                  l_s_valid, l_m_ready, |m0_data, |m1_data, |l_data_in}, 32'd0);
            last_model  = 1'b1;
            in_cnt      = 0;
            out_cnt     = 0;
            perf0_model = 0;
            perf1_model = 0;
            grant_log.delete();
        end else begin
            if (busy && !busy_q) begin
                exp_g = (prev_s0v && prev_s1v) ? !last_model : prev_s1v;
                chk("arb_had_request", prev_s0v || prev_s1v, 1);
                chk("grant_round_robin", grant, exp_g);
                grant_q = exp_g;
                grant_log.push_back(int'(grant));
                in_cnt  = 0;
                out_cnt = 0;
            end
            if (!busy && busy_q) begin
                chk("send_beats", in_cnt, N);
                chk("recv_beats", out_cnt, M);
                last_model = grant_q;
                if (grant_q) perf1_model++;
                else perf0_model++;
            end
            if (!busy) begin
                chk("idle_outputs", {s0_ready, s1_ready, m0_valid, m1_valid, l_s_valid,
                                     l_m_ready, |m0_data, |m1_data, |l_data_in}, 32'd0);
            end else begin
                chk("grant_stable", grant, grant_q);
                if (in_cnt < N) begin
                    chk("send_pass",
                        {l_s_valid, l_data_in, (grant_q ? s1_ready : s0_ready),
                         (grant_q ? s0_ready : s1_ready), l_m_ready, m0_valid, m1_valid,
                         |m0_data, |m1_data},
                        {(grant_q ? s1_valid : s0_valid), (grant_q ? s1_data : s0_data),
                         l_s_ready, 6'b0});
                end else begin
                    chk("recv_pass",
                        {(grant_q ? m1_valid : m0_valid), (grant_q ? m1_data : m0_data),
                         l_m_ready, (grant_q ? m0_valid : m1_valid),
                         |(grant_q ? m0_data : m1_data), l_s_valid, s0_ready, s1_ready},
                        {l_m_valid, l_data_out, (grant_q ? m1_ready : m0_ready), 5'b0});
                    chk("busy_after_last", out_cnt < M, 1);
                end
                if (l_s_valid && l_s_ready) begin
                    in_cnt++;
                    l_in_total++;
                    if (grant_q) begin
                        if (exp_in1.size() == 0) chk("l_data_in_unexpected", 1, 0);
                        else chk("l_data_in_s1", l_data_in, exp_in1.pop_front());
                    end else begin
                        if (exp_in0.size() == 0) chk("l_data_in_unexpected", 1, 0);
                        else chk("l_data_in_s0", l_data_in, exp_in0.pop_front());
                    end
                end
            end
            if (m0_valid && m0_ready) begin
                out_cnt++;
                m0_beats_total++;
                if (exp_m0.size() == 0) chk("m0_unexpected", 1, 0);
                else chk("m0_data", m0_data, exp_m0.pop_front());
            end
            if (m1_valid && m1_ready) begin
                out_cnt++;
                if (exp_m1.size() == 0) chk("m1_unexpected", 1, 0);
                else chk("m1_data", m1_data, exp_m1.pop_front());
            end
        end
        busy_q   = reset ? 1'b0 : busy;
        prev_s0v = s0_valid;
        prev_s1v = s1_valid;
    end

    task automatic drive(input int id, input logic v, input word_t d);
        if (id == 0) begin
            s0_valid = v;
            s0_data  = d;
        end else begin
            s1_valid = v;
            s1_data  = d;
        end
    endtask

    task automatic send_txn(input int id, input vec_t v, input int dly);
        int  sent;
        int  budget;
        bit  hs;
        for (int j = 0; j < N; j++) begin
            if (id == 0) exp_in0.push_back(v[j]);
            else exp_in1.push_back(v[j]);
        end
        for (int k = 0; k < M; k++) begin
            if (id == 0) exp_m0.push_back(mvm_result(v, k));
            else exp_m1.push_back(mvm_result(v, k));
        end
        repeat (dly) @(posedge clk);
        @(posedge clk);
        #1;
        if (abort_req) return;
        drive(id, 1'b1, v[0]);
        sent = 0;
        budget = 0;
        while (sent < N && !abort_req && budget < 3000) begin
            @(negedge clk);
            hs = (id == 0) ? (s0_valid && s0_ready) : (s1_valid && s1_ready);
            @(posedge clk);
            #1;
            budget++;
            if (hs) begin
                sent++;
                if (sent < N) drive(id, 1'b1, v[sent]);
            end
        end
        drive(id, 1'b0, '0);
        if (!abort_req) chk($sformatf("send%0d_complete", id), budget < 3000, 1);
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (k < 3000) begin
            @(negedge clk);
            if (!busy && !s0_valid && !s1_valid && exp_in0.size() == 0 && exp_in1.size() == 0
                && exp_m0.size() == 0 && exp_m1.size() == 0) break;
            k++;
        end
        chk({name, "_done"}, k < 3000, 1);
    endtask

    task automatic flush_sb();
        exp_in0.delete();
        exp_in1.delete();
        exp_m0.delete();
        exp_m1.delete();
    endtask

    vec_t va, vb, vc;
    int   base;
    int   wait_k;
    int   sel;

    initial begin
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        s0_data  = '0;
        s1_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_busy_grant", {busy, grant}, 2'b00);

        // Both valid at first arbitration: 0 wins, then 1, then 0 again.
        va = rand_vec();
        vb = rand_vec();
        vc = rand_vec();
        fork
            begin
                send_txn(0, va, 0);
                send_txn(0, vc, 0);
            end
            send_txn(1, vb, 0);
        join
        wait_done("t035");
        chk("t035_grant_count", grant_log.size(), 3);
        if (grant_log.size() >= 3) begin
            chk("t035_first_grant", grant_log[0], 0);
            chk("t035_second_grant", grant_log[1], 1);
            chk("t035_third_grant", grant_log[2], 0);
        end

        // s0 alone sends 1..8.
        for (int j = 0; j < N; j++) va[j] = word_t'(j + 1);
        base = m0_beats_total;
        send_txn(0, va, 0);
        wait_done("t034");
        chk("t034_m0_beats", m0_beats_total - base, M);
`ifdef MVM_ARB_PERF_EN
        chk("t039_txn_cnt0", txn_cnt0, 3);
        chk("t039_txn_cnt1", txn_cnt1, 1);
`endif

        // Layer input ready toggles 1,0,1,0.
        lsr_mode = 1;
        base = l_in_total;
        send_txn(0, rand_vec(), 0);
        wait_done("t036");
        chk("t036_forwarded_beats", l_in_total - base, N);
        lsr_mode = 0;

        // m0_ready held low for five cycles during RECV.
        va = rand_vec();
        fork
            send_txn(0, va, 0);
            begin
                wait_k = 0;
                while (wait_k < 2000) begin
                    @(negedge clk);
                    if (m0_valid) break;
                    wait_k++;
                end
                chk("t037_reach_recv", wait_k < 2000, 1);
                @(posedge clk);
                #1;
                hold_m0 = 1'b1;
                m0_ready = 1'b0;
                base = m0_beats_total;
                repeat (5) begin
                    @(negedge clk);
                    chk("t037_l_m_ready_low", l_m_ready, 0);
                end
                chk("t037_beats_frozen", m0_beats_total - base, 0);
                chk("t037_still_busy", busy, 1);
                hold_m0 = 1'b0;
            end
        join
        wait_done("t037");

        // Reset after three SEND beats aborts the transaction.
        base = l_in_total;
        fork
            send_txn(0, rand_vec(), 0);
            begin
                wait_k = 0;
                while (wait_k < 2000 && (l_in_total - base) < 3) begin
                    @(negedge clk);
                    wait_k++;
                end
                chk("t038_three_beats", wait_k < 2000, 1);
                @(posedge clk);
                #1;
                abort_req = 1'b1;
                reset = 1'b1;
                @(negedge clk);
                chk("t038_in_reset_busy", busy, 0);
                @(posedge clk);
                #1;
                @(posedge clk);
                #1;
                reset = 1'b0;
                @(negedge clk);
                chk("t038_after_reset", {busy, s0_ready, s1_ready, m0_valid, m1_valid,
                                         l_s_valid, l_m_ready}, 7'd0);
            end
        join
        flush_sb();
        abort_req = 1'b0;
        send_txn(1, rand_vec(), 0);
        wait_done("t038_s1");

        // Randomized contention with random backpressure.
        mr_rand = 1'b1;
        repeat (12) begin
            lsr_mode = $urandom_range(0, 2);
            lmv_rand = 1'($urandom_range(0, 1));
            sel = $urandom_range(1, 3);
            va = rand_vec();
            vb = rand_vec();
            fork
                begin
                    if (sel[0]) send_txn(0, va, $urandom_range(0, 3));
                end
                begin
                    if (sel[1]) send_txn(1, vb, $urandom_range(0, 3));
                end
            join
            wait_done("rand");
        end

`ifdef MVM_ARB_PERF_EN
        chk("perf_txn_cnt0", txn_cnt0, perf0_model);
        chk("perf_txn_cnt1", txn_cnt1, perf1_model);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
